// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// data width and idle line level.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the transmitter (master, issues pops)
// and the FIFO (slave, supplies empty flag and read data).
interface fifo_uart_tx_if;
    import fifo_pkg::*;

    logic              empty;
    logic [DATA_W-1:0] fifo_data;
    logic              remove;

    modport master (output remove, input empty, input fifo_data);
    modport slave  (input remove, output empty, output fifo_data);

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Baud counter: counts clk_out cycles within one serial bit and flags the
// last cycle of the bit. Held at zero while clear is asserted.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_out,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Free-running within a bit, wraps on the last cycle of each bit.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset)                cnt <= '0;
        else if (clear || bit_end) cnt <= '0;
        else                       cnt <= cnt + CW'(1);
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops a byte, waits RD_LAT cycles for read data,
// then sends start, 8 data bits LSB first, optional even parity, stop.
// Optional feature macro: FIFO_UART_PARITY_EN (inserts the parity bit).
// All outputs are registered, so tx/frame_done trail the FSM state by a cycle.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int RD_LAT       = 3
) (
    input  logic                  clk_out,
    input  logic                  reset,
    input  logic                  tx_en,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int WW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    tx_state_e         state, nxt;
    logic [WW-1:0]     wait_cnt;
    logic [DATA_W-1:0] shreg;
    logic [2:0]        bit_idx;
    logic              bit_end;
    logic              wait_last;
    logic              baud_clear;
    logic              can_start;

    assign wait_last  = (wait_cnt == WW'(RD_LAT - 1));
    assign baud_clear = (state == ST_IDLE) || (state == ST_POP) || (state == ST_WAIT);
    assign can_start  = tx_en && !fifo.empty;

    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_out (clk_out),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    // State register.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= nxt;
    end

    // Next-state logic; once POP is issued the frame runs to completion.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (can_start) nxt = ST_POP;
            ST_POP:   nxt = ST_WAIT;
            ST_WAIT:  if (wait_last) nxt = ST_START;
            ST_START: if (bit_end) nxt = ST_DATA;
`ifdef FIFO_UART_PARITY_EN
            ST_DATA:   if (bit_end && bit_idx == 3'd7) nxt = ST_PARITY;
            ST_PARITY: if (bit_end) nxt = ST_STOP;
`else
            ST_DATA:  if (bit_end && bit_idx == 3'd7) nxt = ST_STOP;
`endif
            ST_STOP:  if (bit_end) nxt = can_start ? ST_POP : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            tx          <= LINE_IDLE;
            fifo.remove <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + WW'(1) : '0;
            if (state == ST_WAIT && wait_last) shreg <= fifo.fifo_data;
            if (state != ST_DATA)  bit_idx <= '0;
            else if (bit_end)      bit_idx <= bit_idx + 3'd1;
            fifo.remove <= (nxt == ST_POP);
            busy        <= (nxt != ST_IDLE);
            frame_done  <= (state == ST_STOP) && bit_end;
            case (state)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shreg[bit_idx];
`ifdef FIFO_UART_PARITY_EN
                ST_PARITY: tx <= ^shreg;
`endif
                default:   tx <= LINE_IDLE;
            endcase
        end
    end

endmodule
